// File: rtl/cluster_sequencer_pkg.sv
// Shared constants and FSM state type for the cluster sequencer.
package cluster_sequencer_pkg;

    localparam int MXPADS     = 768;
    localparam int MXCLUSTERS = 8;
    localparam int MXADRBITS  = 11;
    localparam int CNTBITS    = 3;

    // The all-ones address marks an empty slot.
    localparam logic [MXADRBITS-1:0] INVALID_ADR = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/cluster_sequencer_priority_enc_first.sv
// Combinational first-set-bit encoder. It finds the lowest set bit of vec_i and
// returns that bit's index and its 3-bit size field. If no bit is set, it returns
// the all-ones index and a size of 0.
module priority_enc_first
    import cluster_sequencer_pkg::*;
#(
    parameter int WIDTH   = 768,
    parameter int ADRBITS = 11
) (
    input  logic [WIDTH-1:0]         vec_i,
    input  logic [WIDTH*CNTBITS-1:0] cnts_i,
    output logic                     found_o,
    output logic [ADRBITS-1:0]       index_o,
    output logic [CNTBITS-1:0]       cnt_o
);

    // Walk downward so that the lowest set bit is the last one assigned and wins.
    always_comb begin
        found_o = 1'b0;
        index_o = '1;
        cnt_o   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                index_o = ADRBITS'(i);
                cnt_o   = cnts_i[i*CNTBITS +: CNTBITS];
            end
        end
    end

endmodule

// File: rtl/cluster_sequencer.sv
// Cluster sequencer. It latches one frame of pad flags and sizes, then emits
// MXCLUSTERS output slots on consecutive cycles. Each slot is the lowest
// remaining pad. done marks the final slot. overflow reports pads that were
// left over.
// Optional feature: when OVERFLOW_COUNTER_EN is defined, the block adds the
// overflow_cnt output. It is a saturating count of frames that overflowed.
module cluster_sequencer #(
    parameter int MXPADS     = cluster_sequencer_pkg::MXPADS,
    parameter int MXCLUSTERS = cluster_sequencer_pkg::MXCLUSTERS,
    parameter int MXADRBITS  = cluster_sequencer_pkg::MXADRBITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MXPADS-1:0]     vpfs_in,
    input  logic [MXPADS*3-1:0]   cnts_in,
    output logic                  cluster_valid,
    output logic [MXADRBITS-1:0]  cluster_adr,
    output logic [2:0]            cluster_cnt,
    output logic [2:0]            cluster_slot,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
`ifdef OVERFLOW_COUNTER_EN
    ,
    output logic [7:0]            overflow_cnt
`endif
);
    import cluster_sequencer_pkg::*;

    localparam logic [MXADRBITS-1:0] INV_ADR = '1;
    localparam logic [2:0]           LAST    = 3'(MXCLUSTERS - 1);

    state_e                  state_q, state_d;
    logic [MXPADS-1:0]       work_q, work_d;
    logic [MXPADS*3-1:0]     cnts_q, cnts_d;
    logic [2:0]              slot_q, slot_d;
    logic                    valid_q, valid_d;
    logic [MXADRBITS-1:0]    adr_q, adr_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [2:0]              oslot_q, oslot_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;

    logic                    enc_found;
    logic [MXADRBITS-1:0]    enc_index;
    logic [2:0]              enc_cnt;
    logic [MXPADS-1:0]       work_pop;
    logic                    last_slot;

    priority_enc_first #(
        .WIDTH   (MXPADS),
        .ADRBITS (MXADRBITS)
    ) u_enc (
        .vec_i   (work_q),
        .cnts_i  (cnts_q),
        .found_o (enc_found),
        .index_o (enc_index),
        .cnt_o   (enc_cnt)
    );

    // Clearing the lowest set bit is the same as clearing the encoder's winner.
    assign work_pop  = work_q & (work_q - MXPADS'(1));
    assign last_slot = (slot_q == LAST);

    // Next-state logic. Output slots are built here and registered below.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnts_d  = cnts_q;
        slot_d  = slot_q;
        valid_d = 1'b0;
        adr_d   = INV_ADR;
        cnt_d   = '0;
        oslot_d = '0;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = vpfs_in;
                    cnts_d  = cnts_in;
                    slot_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (start && !last_slot) begin
                    // Abort the current frame: emit nothing and restart on the new data.
                    work_d = vpfs_in;
                    cnts_d = cnts_in;
                    slot_d = '0;
                end else begin
                    valid_d = enc_found;
                    adr_d   = enc_index;
                    cnt_d   = enc_cnt;
                    oslot_d = slot_q;
                    work_d  = work_pop;
                    slot_d  = slot_q + 3'd1;
                    if (last_slot) begin
                        done_d = 1'b1;
                        ovf_d  = |work_pop;
                        slot_d = '0;
                        if (start) begin
                            // A back-to-back frame starts with no idle cycle.
                            work_d = vpfs_in;
                            cnts_d = cnts_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset takes priority over start.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnts_q  <= '0;
            slot_q  <= '0;
            valid_q <= 1'b0;
            adr_q   <= INV_ADR;
            cnt_q   <= '0;
            oslot_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnts_q  <= cnts_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            oslot_q <= oslot_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cluster_valid = valid_q;
    assign cluster_adr   = adr_q;
    assign cluster_cnt   = cnt_q;
    assign cluster_slot  = oslot_q;
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign busy          = (state_q == SCAN);

`ifdef OVERFLOW_COUNTER_EN
    logic [7:0] ovf_cnt_q;

    // Count the frames that end with overflow. The count saturates at 255.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else if (done_d && ovf_d && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign overflow_cnt = ovf_cnt_q;
`endif

endmodule
